// File: rtl/sd_crc_engine.sv
// rtl/sd_crc_engine.sv - multi-lane SD CRC7/CRC16 accumulate, shift-out and check engine
// Optional receive-check path (CHECK state, comparator, crc_err) is built only when CRC_CHECK_EN is defined.
module sd_crc_engine #(
  parameter int              CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY = 7'h09,
  parameter int              LANES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     din_valid,
  input  logic [LANES-1:0]         din,
  input  logic                     tx_crc,
  input  logic                     chk_crc,
  output logic [LANES-1:0]         dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic                     done,
  output logic [LANES-1:0]         crc_err,
  output logic [LANES*CRC_W-1:0]   crc_value
);

  localparam int CW = $clog2(CRC_W + 1);
  localparam logic [CW-1:0] LAST = CW'(CRC_W - 1);

`ifdef CRC_CHECK_EN
  typedef enum logic [1:0] {IDLE, ACCUM, SHIFT, CHECK} state_t;
  logic [LANES-1:0] err_q;
  logic             unused_chk;
  assign unused_chk = 1'b0;
  assign crc_err    = err_q;
`else
  typedef enum logic [1:0] {IDLE, ACCUM, SHIFT} state_t;
  logic unused_chk;
  assign unused_chk = chk_crc;
  assign crc_err    = '0;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CRC_W-1:0] crc_q   [LANES];
  logic [CRC_W-1:0] crc_shl [LANES];
  logic [CRC_W-1:0] crc_acc [LANES];
  logic [LANES-1:0] msb;

  always_comb begin
    msb       = '0;
    crc_value = '0;
    for (int i = 0; i < LANES; i++) begin
      msb[i]     = crc_q[i][CRC_W-1];
      crc_shl[i] = {crc_q[i][CRC_W-2:0], 1'b0};
      crc_acc[i] = crc_shl[i] ^ ((din[i] ^ msb[i]) ? POLY : '0);
      crc_value[i*CRC_W +: CRC_W] = crc_q[i];
    end
  end

  assign dout_valid = (state == SHIFT);
  assign dout       = (state == SHIFT) ? msb : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < LANES; i++) crc_q[i] <= '0;
`ifdef CRC_CHECK_EN
      err_q <= '0;
`endif
    end else if (start) begin
      // start aborts any frame in flight without signalling done
      state <= ACCUM;
      cnt   <= '0;
      for (int i = 0; i < LANES; i++) crc_q[i] <= '0;
`ifdef CRC_CHECK_EN
      err_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: ;
        ACCUM: begin
          if (din_valid) begin
            for (int i = 0; i < LANES; i++) crc_q[i] <= crc_acc[i];
          end else if (tx_crc) begin
            state <= SHIFT;
            cnt   <= '0;
`ifdef CRC_CHECK_EN
          end else if (chk_crc) begin
            state <= CHECK;
            cnt   <= '0;
`endif
          end
        end
        SHIFT: begin
          for (int i = 0; i < LANES; i++) crc_q[i] <= crc_shl[i];
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef CRC_CHECK_EN
        CHECK: begin
          if (din_valid) begin
            err_q <= err_q | (din ^ msb);
            for (int i = 0; i < LANES; i++) crc_q[i] <= crc_shl[i];
            if (cnt == LAST) begin
              state <= IDLE;
              cnt   <= '0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_crc_engine.sv
// tb/tb_sd_crc_engine.sv - directed bench for sd_crc_engine (CRC7 command lane and CRC16 4-lane data)
module tb_sd_crc_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       c_start, c_valid, c_din, c_tx, c_chk;
  logic       c_dout, c_dval, c_busy, c_done, c_err;
  logic [6:0] c_crc;

  logic        d_start, d_valid, d_tx, d_chk;
  logic [3:0]  d_din, d_dout, d_err;
  logic        d_dval, d_busy, d_done;
  logic [63:0] d_crc;

  int errors = 0;
  int checks = 0;

  sd_crc_engine u_cmd (
    .clk(clk), .reset(reset), .start(c_start), .din_valid(c_valid), .din(c_din),
    .tx_crc(c_tx), .chk_crc(c_chk), .dout(c_dout), .dout_valid(c_dval),
    .busy(c_busy), .done(c_done), .crc_err(c_err), .crc_value(c_crc)
  );

  sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .LANES(4)) u_dat (
    .clk(clk), .reset(reset), .start(d_start), .din_valid(d_valid), .din(d_din),
    .tx_crc(d_tx), .chk_crc(d_chk), .dout(d_dout), .dout_valid(d_dval),
    .busy(d_busy), .done(d_done), .crc_err(d_err), .crc_value(d_crc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic c_feed(input logic [39:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      c_din   = v[k];
      c_valid = 1'b1;
      tick();
    end
    c_valid = 1'b0;
    c_din   = 1'b0;
  endtask

  task automatic c_begin();
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
  endtask

  // Augmented-message long division: remainder of (n ones) * x^16 mod x^16+x^12+x^5+1
  function automatic logic [15:0] crc16_ones(input int n);
    logic [15:0] r;
    logic        top;
    r = '0;
    for (int k = 0; k < n + 16; k++) begin
      top = r[15];
      r   = {r[14:0], (k < n)};
      if (top) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  initial begin
    logic [6:0]  exp7;
    logic [15:0] exp16;
    reset = 1'b1;
    c_start = 0; c_valid = 0; c_din = 0; c_tx = 0; c_chk = 0;
    d_start = 0; d_valid = 0; d_din = '0; d_tx = 0; d_chk = 0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_crc", c_crc, 0);
    chk("rst_busy", c_busy, 0);
    chk("rst_done", c_done, 0);
    chk("rst_dval", c_dval, 0);
    chk("rst_err", c_err, 0);
    chk("rst_dat_crc", d_crc, 0);

    // CMD0: CRC7 0x4A shifted MSB-first
    c_begin();
    chk("cmd0_busy", c_busy, 1);
    c_feed(40'h4000000000, 40);
    chk("cmd0_crc", c_crc, 7'h4A);
    c_tx = 1'b1;
    tick();
    c_tx = 1'b0;
    exp7 = 7'h4A;
    for (int k = 6; k >= 0; k--) begin
      chk("cmd0_dval", c_dval, 1);
      chk("cmd0_dout", c_dout, exp7[k]);
      chk("cmd0_nodone", c_done, 0);
      tick();
    end
    chk("cmd0_done", c_done, 1);
    chk("cmd0_busy_end", c_busy, 0);
    chk("cmd0_dval_end", c_dval, 0);
    chk("cmd0_crc_end", c_crc, 0);
    tick();
    chk("cmd0_done_pulse", c_done, 0);

    // CMD8: CRC7 0x43, then a din_valid + tx_crc collision accumulates
    c_begin();
    c_feed(40'h48000001AA, 40);
    chk("cmd8_crc", c_crc, 7'h43);
    c_din = 1'b1; c_valid = 1'b1; c_tx = 1'b1;
    tick();
    c_din = 1'b0; c_valid = 1'b0; c_tx = 1'b0;
    chk("coll_crc", c_crc, 7'h06);
    chk("coll_dval", c_dval, 0);
    chk("coll_busy", c_busy, 1);
    tick();
    chk("coll_stay", c_dval, 0);

    // CRC16 4 lanes of all ones
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    d_din = 4'hF; d_valid = 1'b1;
    repeat (1024) tick();
    d_valid = 1'b0; d_din = '0;
    exp16 = crc16_ones(1024);
    for (int l = 0; l < 4; l++) chk($sformatf("dat_crc_l%0d", l), d_crc[l*16 +: 16], exp16);
    d_tx = 1'b1;
    tick();
    d_tx = 1'b0;
    for (int k = 15; k >= 0; k--) begin
      chk("dat_dval", d_dval, 1);
      chk("dat_dout", d_dout, {4{exp16[k]}});
      tick();
    end
    chk("dat_done", d_done, 1);
    chk("dat_crc_end", d_crc, 0);

`ifdef CRC_CHECK_EN
    // Check path, good CRC with gaps
    c_begin();
    c_feed(40'h48000001AA, 40);
    c_chk = 1'b1;
    tick();
    c_chk = 1'b0;
    chk("chk_busy", c_busy, 1);
    exp7 = 7'h43;
    for (int k = 6; k >= 0; k--) begin
      c_valid = 1'b0;
      tick();
      chk("chk_gap_nodone", c_done, 0);
      c_din = exp7[k]; c_valid = 1'b1;
      tick();
    end
    c_valid = 1'b0; c_din = 1'b0;
    chk("chk_ok_done", c_done, 1);
    chk("chk_ok_err", c_err, 0);
    chk("chk_ok_busy", c_busy, 0);

    // Check path, bit 3 flipped
    c_begin();
    c_feed(40'h48000001AA, 40);
    c_chk = 1'b1;
    tick();
    c_chk = 1'b0;
    exp7 = 7'h43 ^ 7'h08;
    for (int k = 6; k >= 0; k--) begin
      c_din = exp7[k]; c_valid = 1'b1;
      tick();
    end
    c_valid = 1'b0; c_din = 1'b0;
    chk("chk_bad_done", c_done, 1);
    chk("chk_bad_err", c_err, 1);
    tick();
    tick();
    chk("chk_bad_sticky", c_err, 1);
    c_begin();
    chk("chk_bad_clr", c_err, 0);
`else
    // TX-only build: chk_crc ignored
    c_begin();
    c_feed(40'h48000001AA, 40);
    c_chk = 1'b1;
    tick();
    tick();
    c_chk = 1'b0;
    chk("nochk_busy", c_busy, 1);
    chk("nochk_done", c_done, 0);
    chk("nochk_err", c_err, 0);
    chk("nochk_crc", c_crc, 7'h43);
`endif

    // Abort mid-SHIFT at the fourth shift cycle
    c_begin();
    c_feed(40'h4000000000, 40);
    c_tx = 1'b1;
    tick();
    c_tx = 1'b0;
    repeat (3) tick();
    chk("abort_pre_dval", c_dval, 1);
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    chk("abort_dval", c_dval, 0);
    chk("abort_done", c_done, 0);
    chk("abort_crc", c_crc, 0);
    chk("abort_busy", c_busy, 1);
    tick();
    chk("abort_nodone", c_done, 0);

    // Reset mid-ACCUM
    c_feed(40'h48, 8);
    chk("racc_crc_nz", (c_crc != 0), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("racc_crc", c_crc, 0);
    chk("racc_busy", c_busy, 0);
    chk("racc_dval", c_dval, 0);
    chk("racc_done", c_done, 0);
    chk("racc_dout", c_dout, 0);
    chk("racc_err", c_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_crc_engine.md
# sd_crc_engine

Parametrised multi-lane CRC engine for the SD host datapath. It covers both command CRC7 (1 lane) and data-line CRC16 (1 or 4 lanes). For each lane it accumulates a CRC over serial bits, then either shifts the CRC out MSB-first for transmission or compares it against CRC bits received from the card. It sits between the command/data serialisers and the SD pins, and is driven by the command and data controllers.

## Interface
- CRC_W, 7: CRC register width per lane (7 for CMD, 16 for DAT).
- POLY, 7'h09: generator polynomial without the x^CRC_W term (16'h1021 for CRC16).
- LANES, 1: number of independent parallel lanes (1 or 4).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; returns the block to IDLE and zeroes all state.
- start  in  1  begins a new frame: zeroes all CRC registers and enters ACCUM (valid in any state).
- din_valid  in  1  qualifies din this cycle.
- din  in  LANES  serial data bit per lane (lane i = din[i]).
- tx_crc  in  1  request to shift the accumulated CRC out (ACCUM only).
- chk_crc  in  1  request to compare the next CRC_W received bits (ACCUM only).
- dout  out  LANES  CRC bit per lane during SHIFT; 0 otherwise.
- dout_valid  out  1  high in every SHIFT cycle.
- busy  out  1  high in ACCUM, SHIFT and CHECK.
- done  out  1  one-cycle pulse at the end of SHIFT or CHECK.
- crc_err  out  LANES  per-lane mismatch flag; sticky until start or reset.
- crc_value  out  LANES*CRC_W  live CRC registers; lane i occupies bits [i*CRC_W +: CRC_W].

## Operation
- States: IDLE, ACCUM, SHIFT, CHECK. Reset gives IDLE, all CRC registers 0, counter 0, and every output 0.
- Lane update on an ACCUM cycle with din_valid: fb = din[i] ^ crc[i][CRC_W-1]; crc[i] <= {crc[i][CRC_W-2:0],1'b0} ^ (fb ? POLY : 0). This matches the standard SD CRC7/CRC16 with init 0.
- IDLE: registers hold their value; din_valid, tx_crc and chk_crc are ignored. start goes to ACCUM.
- ACCUM:
  - din_valid has priority. If tx_crc or chk_crc is asserted in the same cycle as din_valid, the data bit is accumulated and the request is dropped.
  - tx_crc with din_valid low goes to SHIFT.
  - chk_crc with din_valid low goes to CHECK.
  - If tx_crc and chk_crc are both high, tx_crc wins.
- SHIFT: runs for exactly CRC_W cycles.
  - Each cycle dout[i] = crc[i][CRC_W-1], and the registers shift left filling with 0.
  - din_valid is ignored.
  - After the last bit the engine goes to IDLE and pulses done.
- CHECK: each din_valid cycle compares din[i] against crc[i][CRC_W-1].
  - On a mismatch, crc_err[i] is set.
  - The registers then shift left filling with 0.
  - The counter advances only on din_valid. After CRC_W valid bits the engine goes to IDLE and pulses done.
- start in any state zeroes the registers, counter and crc_err, aborts SHIFT/CHECK without a done pulse, and enters ACCUM. reset overrides start.
- Bit counter width is clog2(CRC_W+1). It wraps to 0 on every state entry.

## Timing
- Register update takes effect on the edge that samples din_valid; crc_value reflects it the next cycle.
- SHIFT: the first CRC bit is on dout in the cycle after the accepting tx_crc edge. dout_valid stays high for exactly CRC_W consecutive cycles. done is high for one cycle on the cycle immediately following the last bit (state = IDLE).
- CHECK: crc_err[i] updates on the edge sampling the mismatching bit. done follows the CRC_W-th valid bit by one cycle. The final crc_err value is stable when done is high.
- busy falls in the same cycle done rises.
- After a completed frame the registers are all zero, so crc_value = 0 in IDLE.

## Configuration
- CRC_CHECK_EN defined: the CHECK state, comparator and crc_err registers are built.
- CRC_CHECK_EN undefined: chk_crc is ignored (ACCUM stays in ACCUM), crc_err is tied to 0, and the CHECK state is absent. Generate-only area reduction for the TX-only build.

## Test plan
- CMD0 frame: CRC_W=7, POLY=7'h09, LANES=1; start, then 40 bits of 0x4000000000; tx_crc -> dout sequence 1001010 (0x4A) over 7 cycles with dout_valid high, then done=1 for 1 cycle.
- CMD8 frame: 0x48000001AA -> crc_value=7'h43 before tx_crc. A din_valid plus tx_crc collision cycle accumulates the bit and stays in ACCUM.
- CRC16 4-lane: CRC_W=16, POLY=16'h1021, LANES=4; 1024 cycles of din=4'hF -> each lane's crc_value = 16'h7FA1; tx_crc shifts 0x7FA1 MSB-first on all lanes.
- Check path (CRC_CHECK_EN): accumulate CMD8 payload, chk_crc, feed 0x43 with din_valid gaps -> crc_err=0, done after the 7th valid bit. Repeat with bit 3 flipped -> crc_err=1 until the next start.
- Abort: start asserted mid-SHIFT (cycle 3) -> dout_valid drops next cycle, no done pulse, crc_value=0, state ACCUM. reset mid-ACCUM -> all outputs 0 the next cycle.
- Build without CRC_CHECK_EN: chk_crc asserted in ACCUM -> busy stays 1, no done, crc_err=0.
